mem_access_unit: RTL and testbench

- Initiator-side load/store unit between the MIPS core's MEM stage and the word-organised data memory.
- The data memory has a combinational read, a synchronous write, and word access only.
- Accepts byte, halfword and word loads/stores (lb/lbu/lh/lhu/lw/sb/sh/sw) through a valid/ready request and a one-cycle response pulse.
- Sub-word stores are done as a read-modify-write sequence; misaligned and out-of-range accesses are flagged and never reach memory.

---
 rtl/mem_access_unit_pkg.sv | 15 +
 rtl/mem_access_unit_if.sv | 34 +++
 rtl/mem_access_unit_lane_align.sv | 38 +++
 rtl/mem_access_unit.sv | 119 +++++++++++
 tb/tb_mem_access_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store unit: access sizes and FSM state encoding.
package cpu_defs;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      RESP = 2'd3
   } state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Core request/response handshake plus the word-memory bus of the load/store unit.
interface mem_access_unit_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_signed;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [31:0] req_pc;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] mem_pc;

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc, mem_rdata,
      output req_ready, resp_valid, resp_err, resp_rdata,
             mem_read, mem_write, mem_addr, mem_wdata, mem_pc
   );

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, req_pc, mem_rdata,
      input  req_ready, resp_valid, resp_err, resp_rdata,
             mem_read, mem_write, mem_addr, mem_wdata, mem_pc
   );

endinterface

// File: rtl/mem_access_unit_lane_align.sv
// Little-endian lane handling: extract/extend for loads, lane merge for stores.
module lane_align
   import cpu_defs::*;
(
   input  logic [31:0] rdWord,
   input  logic [31:0] baseWord,
   input  logic [31:0] wdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        isSigned,
   output logic [31:0] loadData,
   output logic [31:0] mergedWord
);

   logic signed [7:0]  byteVal;
   logic signed [15:0] halfVal;

   always_comb begin
      byteVal = rdWord[{offset, 3'b000} +: 8];
      halfVal = rdWord[{offset[1], 4'b0000} +: 16];
      case (size)
         SIZE_BYTE: loadData = isSigned ? 32'(byteVal) : {24'd0, byteVal};
         SIZE_HALF: loadData = isSigned ? 32'(halfVal) : {16'd0, halfVal};
         default:   loadData = rdWord;
      endcase
   end

   // Word stores bypass the merge entirely, so the default is the raw store data.
   always_comb begin
      mergedWord = baseWord;
      case (size)
         SIZE_BYTE: mergedWord[{offset, 3'b000} +: 8]    = wdata[7:0];
         SIZE_HALF: mergedWord[{offset[1], 4'b0000} +: 16] = wdata[15:0];
         default:   mergedWord = wdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a word-organised data memory;
// sub-word stores run as read-modify-write, bad accesses never reach memory.
module mem_access_unit
   import cpu_defs::*;
#(
   parameter int MEM_WORDS   = 1024,
   parameter bit CHECK_RANGE = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   mem_access_unit_if.slave  bus
);

   localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

   state_t      state, nextState;
   logic        latWe, latSigned, respErr;
   logic [1:0]  latSize;
   logic [31:0] latAddr, latWdata, latPc, mergeWord, respRdata;
   logic [31:0] loadData, mergedWord;
   logic        misaligned, outOfRange, reqBad;

   always_comb begin
      misaligned = (bus.req_size == 2'd3)
                 || (bus.req_size == SIZE_HALF && bus.req_addr[0])
                 || (bus.req_size == SIZE_WORD && bus.req_addr[1:0] != 2'b00);
      outOfRange = CHECK_RANGE && ({1'b0, bus.req_addr} >= ADDR_LIMIT);
      reqBad     = misaligned || outOfRange;
   end

   lane_align uLane (
      .rdWord     (bus.mem_rdata),
      .baseWord   (mergeWord),
      .wdata      (latWdata),
      .offset     (latAddr[1:0]),
      .size       (latSize),
      .isSigned   (latSigned),
      .loadData   (loadData),
      .mergedWord (mergedWord)
   );

   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               if (reqBad)
                  nextState = RESP;
               else if (bus.req_we && bus.req_size == SIZE_WORD)
                  nextState = WR;
               else
                  nextState = RD;
            end
         end
         RD:      nextState = latWe ? WR : RESP;
         WR:      nextState = RESP;
         RESP:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         latWe     <= 1'b0;
         latSigned <= 1'b0;
         latSize   <= 2'd0;
         latAddr   <= 32'd0;
         latWdata  <= 32'd0;
         latPc     <= 32'd0;
         mergeWord <= 32'd0;
         respRdata <= 32'd0;
         respErr   <= 1'b0;
      end else begin
         state <= nextState;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  latWe     <= bus.req_we;
                  latSigned <= bus.req_signed;
                  latSize   <= bus.req_size;
                  latAddr   <= bus.req_addr;
                  latWdata  <= bus.req_wdata;
                  latPc     <= bus.req_pc;
                  if (reqBad) begin
                     respErr   <= 1'b1;
                     respRdata <= 32'd0;
                  end
               end
            end
            RD: begin
               if (latWe) begin
                  mergeWord <= bus.mem_rdata;
               end else begin
                  respRdata <= loadData;
                  respErr   <= 1'b0;
               end
            end
            WR: begin
               respRdata <= 32'd0;
               respErr   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   // Strobes come from state alone so an async reset kills them at once.
   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_err   = respErr;
   assign bus.resp_rdata = respRdata;
   assign bus.mem_read   = (state == RD);
   assign bus.mem_write  = (state == WR);
   assign bus.mem_addr   = (state == RD || state == WR) ? {latAddr[31:2], 2'b00} : 32'd0;
   assign bus.mem_wdata  = (state == WR) ? mergedWord : 32'd0;
   assign bus.mem_pc     = (state == WR) ? latPc : 32'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with a behavioural word memory.
module tb_mem_access_unit;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   mem_access_unit_if bus();

   mem_access_unit #(.MEM_WORDS(1024), .CHECK_RANGE(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [31:0] memArr [0:1023];
   assign bus.mem_rdata = memArr[bus.mem_addr[11:2]];
   always @(posedge clk) if (bus.mem_write) memArr[bus.mem_addr[11:2]] <= bus.mem_wdata;

   typedef struct {
      logic        err;
      logic [31:0] data;
      int          lat;
   } exp_t;
   exp_t sbQ[$];

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic doReq(input bit we, input logic [1:0] sz, input bit sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                        input bit expErr, input logic [31:0] expData, input int expLat,
                        input int expRd, input int expWr, input logic [31:0] expWdata);
      int n, rdCnt, wrCnt;
      exp_t e;
      n = 0;
      while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
      check("readyIdle", 32'(bus.req_ready), 32'd1);
      bus.req_we = we; bus.req_size = sz; bus.req_signed = sg;
      bus.req_addr = a; bus.req_wdata = wd; bus.req_pc = pc; bus.req_valid = 1'b1;
      e.err = expErr; e.data = expData; e.lat = expLat;
      sbQ.push_back(e);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      n = 0; rdCnt = 0; wrCnt = 0;
      while (!bus.resp_valid && n < 10) begin
         check("busyReady", 32'(bus.req_ready), 32'd0);
         check("addrAlign", bus.mem_addr, {a[31:2], 2'b00});
         if (bus.mem_read) rdCnt++;
         if (bus.mem_write) begin
            wrCnt++;
            check("memWdata", bus.mem_wdata, expWdata);
            check("memPc", bus.mem_pc, pc);
         end
         @(posedge clk); #1;
         n++;
      end
      if (!bus.resp_valid) check("respTimeout", 32'd0, 32'd1);
      check("respReady", 32'(bus.req_ready), 32'd0);
      check("respMemAddr", bus.mem_addr, 32'd0);
      e = sbQ.pop_front();
      check("respErr", 32'(bus.resp_err), 32'(e.err));
      check("respRdata", bus.resp_rdata, e.data);
      check("latency", 32'(n), 32'(e.lat));
      check("rdCount", 32'(rdCnt), 32'(expRd));
      check("wrCount", 32'(wrCnt), 32'(expWr));
      @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) memArr[i] = 32'd0;
      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_signed = 1'b0;
      bus.req_addr = 32'd0; bus.req_wdata = 32'd0; bus.req_pc = 32'd0;

      // Reset values
      #12;
      check("rstReady", 32'(bus.req_ready), 32'd1);
      check("rstRespValid", 32'(bus.resp_valid), 32'd0);
      check("rstRespErr", 32'(bus.resp_err), 32'd0);
      check("rstRdata", bus.resp_rdata, 32'd0);
      check("rstStrobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
      check("rstMemAddr", bus.mem_addr, 32'd0);
      check("rstMemWdata", bus.mem_wdata, 32'd0);
      check("rstMemPc", bus.mem_pc, 32'd0);
      @(negedge clk); reset = 1'b1;
      @(negedge clk);

      // Reset asserted in the middle of a load's RD cycle
      bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_addr = 32'h10; bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("midRdRead", 32'(bus.mem_read), 32'd1);
      reset = 1'b0; #1;
      check("midRdReadDrop", 32'(bus.mem_read), 32'd0);
      check("midRdReady", 32'(bus.req_ready), 32'd1);
      @(negedge clk); reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("postRstNoResp", 32'(bus.resp_valid), 32'd0);
         check("postRstReady", 32'(bus.req_ready), 32'd1);
      end

      // Word store then word load
      doReq(1, 2'd2, 0, 32'h8, 32'hDEADBEEF, 32'h0040_0100, 0, 32'd0, 1, 0, 1, 32'hDEADBEEF);
      doReq(0, 2'd2, 0, 32'h8, 32'd0, 32'h0040_0104, 0, 32'hDEADBEEF, 1, 1, 0, 32'd0);

      // Sub-word loads on 0xDEADBEEF
      doReq(0, 2'd0, 1, 32'h9, 32'd0, 32'h108, 0, 32'hFFFFFFBE, 1, 1, 0, 32'd0);
      doReq(0, 2'd0, 0, 32'h9, 32'd0, 32'h10C, 0, 32'h000000BE, 1, 1, 0, 32'd0);
      doReq(0, 2'd1, 1, 32'hA, 32'd0, 32'h110, 0, 32'hFFFFDEAD, 1, 1, 0, 32'd0);
      doReq(0, 2'd1, 0, 32'h8, 32'd0, 32'h114, 0, 32'h0000BEEF, 1, 1, 0, 32'd0);
      doReq(0, 2'd0, 1, 32'hB, 32'd0, 32'h118, 0, 32'hFFFFFFDE, 1, 1, 0, 32'd0);

      // Read-modify-write stores
      doReq(1, 2'd0, 0, 32'hB, 32'h12, 32'h200, 0, 32'd0, 2, 1, 1, 32'h12ADBEEF);
      doReq(1, 2'd1, 0, 32'h8, 32'h3456, 32'h204, 0, 32'd0, 2, 1, 1, 32'h12AD3456);
      doReq(0, 2'd2, 0, 32'h8, 32'd0, 32'h208, 0, 32'h12AD3456, 1, 1, 0, 32'd0);
      doReq(0, 2'd1, 1, 32'h8, 32'd0, 32'h20C, 0, 32'h00003456, 1, 1, 0, 32'd0);

      // Error cases never touch memory
      doReq(0, 2'd2, 0, 32'h6, 32'd0, 32'h300, 1, 32'd0, 0, 0, 0, 32'd0);
      doReq(0, 2'd1, 0, 32'h3, 32'd0, 32'h304, 1, 32'd0, 0, 0, 0, 32'd0);
      doReq(0, 2'd3, 0, 32'h0, 32'd0, 32'h308, 1, 32'd0, 0, 0, 0, 32'd0);
      doReq(1, 2'd2, 0, 32'h1000, 32'h55, 32'h30C, 1, 32'd0, 0, 0, 0, 32'd0);
      doReq(0, 2'd2, 0, 32'hFFC, 32'd0, 32'h310, 0, 32'd0, 1, 1, 0, 32'd0);

      // Back-to-back loads with req_valid held high
      @(negedge clk);
      bus.req_we = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
      bus.req_addr = 32'h8; bus.req_valid = 1'b1;
      @(posedge clk); #1;
      bus.req_size = 2'd1; bus.req_addr = 32'hA; bus.req_signed = 1'b0;
      check("b2bRdRead", 32'(bus.mem_read), 32'd1);
      check("b2bRdReady", 32'(bus.req_ready), 32'd0);
      check("b2bRdAddr", bus.mem_addr, 32'h8);
      @(posedge clk); #1;
      check("b2bResp1", 32'(bus.resp_valid), 32'd1);
      check("b2bRespReady", 32'(bus.req_ready), 32'd0);
      check("b2bData1", bus.resp_rdata, 32'h12AD3456);
      @(posedge clk); #1;
      check("b2bIdleReady", 32'(bus.req_ready), 32'd1);
      check("b2bIdleNoRead", 32'(bus.mem_read), 32'd0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      check("b2bRd2Read", 32'(bus.mem_read), 32'd1);
      check("b2bRd2Addr", bus.mem_addr, 32'h8);
      @(posedge clk); #1;
      check("b2bResp2", 32'(bus.resp_valid), 32'd1);
      check("b2bData2", bus.resp_rdata, 32'h000012AD);
      @(posedge clk); #1;
      check("b2bHold", bus.resp_rdata, 32'h000012AD);
      check("b2bPulse", 32'(bus.resp_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
